// File: rtl/slow_multiplication.sv
// Rebuilds dividend = quotient*divisor + remainder by shift-and-add, one divisor bit per clock.
// Latency: done pulses DW cycles after start is accepted; one operation per DW+1 cycles.
// Backpressure: start is ignored while busy; dividend and error flags hold until the next done.
module slow_multiplication #(
    parameter int QW = 8,
    parameter int DW = 4,
    localparam int PW = QW + DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [QW-1:0] quotient,
    input  logic [DW-1:0] divisor,
    input  logic [DW-1:0] remainder,
    output logic          busy,
    output logic          done,
    output logic [PW-1:0] dividend,
    output logic          err_div0,
    output logic          err_rem
);

    // Iteration counter only has to reach DW-1.
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] acc;
    logic [PW-1:0] mcand;
    logic [DW-1:0] mplier;
    logic [CW-1:0] cnt;
    logic          div0_q;
    logic          rem_q;
    logic [PW-1:0] acc_sum;

    // Partial product for this iteration; the final iteration's sum goes straight to dividend.
    always_comb begin
        acc_sum = acc;
        if (mplier[0]) begin
            acc_sum = acc + mcand;
        end
    end

    // Sequencer: capture on accept, shift-add through CALC, publish results on the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            dividend <= '0;
            err_div0 <= 1'b0;
            err_rem  <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            div0_q   <= 1'b0;
            rem_q    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        acc    <= PW'(remainder);
                        mcand  <= PW'(quotient);
                        mplier <= divisor;
                        cnt    <= '0;
                        // A zero divisor only makes the remainder illegal when it is non-zero.
                        div0_q <= (divisor == '0);
                        rem_q  <= (remainder >= divisor) && (remainder != '0);
                        busy   <= 1'b1;
                        state  <= CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(DW - 1)) begin
                        dividend <= acc_sum;
                        err_div0 <= div0_q;
                        err_rem  <= rem_q;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slow_multiplication.sv
module tb_slow_multiplication;

    localparam int QW = 8;
    localparam int DW = 4;
    localparam int PW = QW + DW;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [QW-1:0] quotient;
    logic [DW-1:0] divisor;
    logic [DW-1:0] remainder;
    logic          busy;
    logic          done;
    logic [PW-1:0] dividend;
    logic          err_div0;
    logic          err_rem;

    slow_multiplication #(.QW(QW), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .quotient (quotient),
        .divisor  (divisor),
        .remainder(remainder),
        .busy     (busy),
        .done     (done),
        .dividend (dividend),
        .err_div0 (err_div0),
        .err_rem  (err_rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] val;
        bit            e0;
        bit            er;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   next_ok = 0;
    bit   have_op = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: an operation is accepted when start is seen and the unit has had
    // DW+1 cycles since the previous acceptance; the result is plain integer arithmetic.
    always @(posedge clk) begin
        exp_t e;
        int   qi, di, ri;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            next_ok = cyc;
            have_op = 0;
        end else if (start && cyc >= next_ok) begin
            qi    = int'(quotient);
            di    = int'(divisor);
            ri    = int'(remainder);
            e.val = PW'(qi * di + ri);
            e.e0  = (di == 0);
            e.er  = (di == 0) ? (ri > 0) : (ri >= di);
            exp_q.push_back(e);
            next_ok = cyc + DW + 1;
            have_op = 1;
        end
    end

    // Monitor: checks handshake timing every cycle and pops the scoreboard on each done.
    logic [PW-1:0] last_val = '0;
    bit            last_e0  = 0;
    bit            last_er  = 0;
    always @(negedge clk) begin
        exp_t e;
        bit   exp_busy, exp_done;
        if (!rst_n) begin
            last_val = '0;
            last_e0  = 0;
            last_er  = 0;
        end else begin
            exp_busy = have_op && (cyc < next_ok - 1);
            exp_done = have_op && (cyc == next_ok - 1);
            check("busy", 32'(busy), 32'(exp_busy));
            check("done", 32'(done), 32'(exp_done));
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("done_without_op", 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("dividend", 32'(dividend), 32'(e.val));
                    check("err_div0", 32'(err_div0), 32'(e.e0));
                    check("err_rem", 32'(err_rem), 32'(e.er));
                    last_val = e.val;
                    last_e0  = e.e0;
                    last_er  = e.er;
                end
            end else begin
                check("hold_dividend", 32'(dividend), 32'(last_val));
                check("hold_flags", 32'({err_div0, err_rem}), 32'({last_e0, last_er}));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Issue one start pulse and return in the DONE cycle, ready for a back-to-back start.
    task automatic issue(input int q, input int d, input int r);
        start     = 1'b1;
        quotient  = QW'(q);
        divisor   = DW'(d);
        remainder = DW'(r);
        step(1);
        start = 1'b0;
        step(DW);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; quotient = '0; divisor = '0; remainder = '0;
        step(2);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_dividend", 32'(dividend), 0);
        check("rst_flags", 32'({err_div0, err_rem}), 0);
        rst_n = 1'b1;
        step(1);

        // Directed operations, the second pair issued back-to-back on the DONE cycle.
        issue(6, 5, 2);
        issue(8, 9, 1);
        step(2);
        issue(255, 15, 14);
        issue(0, 15, 0);
        step(1);
        issue(10, 0, 3);
        issue(7, 4, 4);
        step(3);

        // Start held high with inputs changing every cycle.
        for (int i = 0; i < 10; i++) begin
            start     = 1'b1;
            quotient  = QW'($urandom);
            divisor   = DW'($urandom);
            remainder = DW'($urandom);
            step(1);
        end
        start = 1'b0;
        step(DW + 2);

        // Reset two cycles into CALC: outputs clear at once and the op never completes.
        start = 1'b1; quotient = 8'd200; divisor = 4'd13; remainder = 4'd5;
        step(1);
        start = 1'b0;
        step(1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        check("arst_dividend", 32'(dividend), 0);
        check("arst_flags", 32'({err_div0, err_rem}), 0);
        step(1);
        rst_n = 1'b1;
        step(1);
        issue(3, 3, 2);
        step(2);

        // Randomized operations with random idle gaps, including back-to-back.
        for (int i = 0; i < 40; i++) begin
            issue(int'($urandom_range(255, 0)), int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
            step(int'($urandom_range(2, 0)));
        end
        step(DW + 3);
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
